fifo_ctrl: RTL and testbench
============================

FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, meaning the data word width.
REQ-002 The block SHALL have parameter ADDR_W, default 3, meaning the RAM address width (depth 2^ADDR_W = 8).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_L, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port enable, input, 1 bit: while 0, no push or pop is accepted.
REQ-006 The block SHALL have port push, input, 1 bit: write request.
REQ-007 The block SHALL have port pop, input, 1 bit: read request.
REQ-008 The block SHALL have port data_in, input, DATA_W: write data.
REQ-009 The block SHALL have port th_high, input, ADDR_W: almost-full threshold, latched in INIT.
REQ-010 The block SHALL have port th_low, input, ADDR_W: almost-empty threshold, latched in INIT.
REQ-011 The block SHALL have port ram_state, output, 2: RAM command; 0 idle, 1 read, 2 write, 3 read+write.
REQ-012 The block SHALL have port ram_data_in, output, DATA_W: RAM write data.
REQ-013 The block SHALL have port ram_addr_in, output, ADDR_W: RAM write address.
REQ-014 The block SHALL have port ram_addr_out, output, ADDR_W: RAM read address.
REQ-015 The block SHALL have port rd_valid, output, 1: RAM read data valid this cycle.
REQ-016 The block SHALL have ports full, empty, almost_full, almost_empty, output, 1 bit each: status flags.
REQ-017 The block SHALL have port count, output, ADDR_W+1: current occupancy, 0..8.
REQ-018 The block SHALL have port error, output, 1: sticky overflow/underflow flag.

Function
REQ-019 FSM states SHALL be RESET, INIT, IDLE, ACTIVE, ERROR.
REQ-020 Transitions SHALL be: RESET->INIT on the first clock after reset release; INIT->IDLE after one cycle, with th_high/th_low latched; IDLE->ACTIVE on an accepted push; ACTIVE->IDLE when count reaches 0; any state->ERROR on overflow or underflow.
REQ-021 ERROR SHALL be left only by reset.
REQ-022 Push SHALL be accepted when enable=1, state is IDLE or ACTIVE, and push=1 with (not full, or pop accepted in the same cycle).
REQ-023 Pop SHALL be accepted when enable=1, state is ACTIVE, pop=1 and not empty.
REQ-024 ram_state, ram_addr_in (=wr_ptr), ram_addr_out (=rd_ptr) and ram_data_in (=data_in) SHALL be combinational from the accepted requests in the same cycle; ram_state is 0 when nothing is accepted.
REQ-025 wr_ptr SHALL increment modulo 8 after each accepted push, and rd_ptr after each accepted pop (7->0 wrap).
REQ-026 count SHALL be +1 for a push only, -1 for a pop only, and unchanged for both or neither.
REQ-027 rd_valid SHALL be registered: asserted exactly one cycle after an accepted pop, matching the RAM's one-cycle read latency.
REQ-028 Flags SHALL be combinational from count: full (count==8), empty (count==0), almost_full (count>=th_high latched), almost_empty (count<=th_low latched).
REQ-029 A push while full without a simultaneous accepted pop SHALL be dropped and set error (overflow).
REQ-030 A pop while empty SHALL be dropped and set error (underflow), including when a push occurs in the same cycle; that push is still accepted.
REQ-031 Push and pop together while full SHALL both be accepted, with ram_state=3 and the same address on both ports; the RAM returns pre-write data.
REQ-032 With enable=0, requests SHALL be ignored without setting error, and all registers SHALL hold.
REQ-033 In ERROR, no requests SHALL be accepted and ram_state SHALL be 0.

Reset
REQ-034 While reset_L=0, the FSM SHALL be in RESET, pointers and count 0, thresholds 0, rd_valid 0, and error 0.
REQ-035 During reset, outputs SHALL be ram_state 0, empty 1, full 0, and almost_empty 1.
REQ-036 Reset asserted mid-operation SHALL discard contents immediately and asynchronously, and no RAM command SHALL be issued.

Structure
REQ-037 Package fifo_pkg SHALL hold the ram_state encodings (IDLE=0, RD=1, WR=2, RW=3) and the FSM state encoding.
REQ-038 One sub-module, fifo_ptr (modulo-8 pointer with increment enable, async reset), SHALL be instantiated twice.

Verification
REQ-039 Reset, then 8 pushes of data 1..8 -> count 8, full=1, ram_addr_in 0..7, ram_state=2 each cycle.
REQ-040 Continue with 8 pops -> ram_addr_out 0..7, rd_valid one cycle later each, RAM data 1..8, empty=1, FSM IDLE.
REQ-041 Fill to 8, then push+pop together for 4 cycles -> ram_state=3, count stays 8, both pointers wrap 0..3.
REQ-042 With th_high=6 and th_low=2, push to count 6 -> almost_full=1 at count 6, almost_empty=0 from count 3.
REQ-043 Ninth push while full -> dropped, error=1, FSM ERROR, ram_state 0 until reset_L=0.
REQ-044 enable=0 with push=1 for 3 cycles -> count unchanged, error 0; reset_L pulsed low mid-stream -> count 0, empty=1 asynchronously.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared encodings for the FIFO controller: RAM command codes and controller FSM states.
package fifo_pkg;

  typedef enum logic [1:0] {
    RAM_IDLE = 2'd0,
    RAM_RD   = 2'd1,
    RAM_WR   = 2'd2,
    RAM_RW   = 2'd3
  } ram_cmd_e;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } fsm_state_e;

  function automatic ram_cmd_e ram_cmd(input logic wr, input logic rd);
    return ram_cmd_e'({wr, rd});
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping RAM pointer, advances by one when inc is high; no backpressure.
// Latency: new value visible the cycle after inc.
module fifo_ptr #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller driving an external 1-cycle-latency RAM; RAM command is same-cycle, rd_valid one cycle later.
// Backpressure: pushes refused when full unless paired with a pop; overflow/underflow lock into ERROR until reset.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              enable,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] th_high,
  input  logic [ADDR_W-1:0] th_low,
  output logic [1:0]        ram_state,
  output logic [DATA_W-1:0] ram_data_in,
  output logic [ADDR_W-1:0] ram_addr_in,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              error
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);

  fsm_state_e        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] th_high_q;
  logic [ADDR_W-1:0] th_low_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_nxt;
  logic              req_ok;
  logic              push_acc;
  logic              pop_acc;
  logic              overflow;
  logic              underflow;

  // Only IDLE/ACTIVE take requests; IDLE always holds an empty FIFO, so pops there are underflows.
  assign req_ok    = enable && (state == ST_IDLE || state == ST_ACTIVE);
  assign pop_acc   = req_ok && (state == ST_ACTIVE) && pop && !empty;
  assign push_acc  = req_ok && push && (!full || pop_acc);
  assign overflow  = req_ok && push && full && !pop_acc;
  assign underflow = req_ok && pop && empty;

  always_comb begin
    count_nxt = count_q;
    case ({push_acc, pop_acc})
      2'b10:   count_nxt = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_nxt = count_q - (ADDR_W + 1)'(1);
      default: count_nxt = count_q;
    endcase
  end

  fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (reset_L),
    .inc   (push_acc),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (reset_L),
    .inc   (pop_acc),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state     <= ST_RESET;
      count_q   <= '0;
      th_high_q <= '0;
      th_low_q  <= '0;
      rd_valid  <= 1'b0;
      error     <= 1'b0;
    end else begin
      count_q  <= count_nxt;
      rd_valid <= pop_acc;
      if (overflow || underflow) begin
        state <= ST_ERROR;
        error <= 1'b1;
      end else begin
        case (state)
          ST_RESET:  state <= ST_INIT;
          ST_INIT: begin
            th_high_q <= th_high;
            th_low_q  <= th_low;
            state     <= ST_IDLE;
          end
          ST_IDLE:   if (push_acc) state <= ST_ACTIVE;
          ST_ACTIVE: if (count_nxt == '0) state <= ST_IDLE;
          default:   state <= state;
        endcase
      end
    end
  end

  assign ram_state    = ram_cmd(push_acc, pop_acc);
  assign ram_data_in  = data_in;
  assign ram_addr_in  = wr_ptr;
  assign ram_addr_out = rd_ptr;
  assign count        = count_q;
  assign full         = (count_q == CNT_FULL);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= {1'b0, th_high_q});
  assign almost_empty = (count_q <= {1'b0, th_low_q});

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: behavioural RAM plus a data scoreboard checked on rd_valid.
module tb_fifo_ctrl;
  import fifo_pkg::*;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset_L, enable, push, pop;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] th_high, th_low;
  logic [1:0]        ram_state;
  logic [DATA_W-1:0] ram_data_in;
  logic [ADDR_W-1:0] ram_addr_in, ram_addr_out;
  logic              rd_valid, full, empty, almost_full, almost_empty, error;
  logic [ADDR_W:0]   count;

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] mem [8];
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] sb [$];
  logic [DATA_W-1:0] sb_exp;

  always #5 clk = ~clk;

  fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_L(reset_L), .enable(enable), .push(push), .pop(pop),
    .data_in(data_in), .th_high(th_high), .th_low(th_low),
    .ram_state(ram_state), .ram_data_in(ram_data_in), .ram_addr_in(ram_addr_in),
    .ram_addr_out(ram_addr_out), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count), .error(error)
  );

  // One-cycle-latency RAM; a same-cycle read returns the pre-write word.
  always @(posedge clk) begin
    if (ram_state[1]) mem[ram_addr_in] <= ram_data_in;
    if (ram_state[0]) rd_data <= mem[ram_addr_out];
  end

  always @(negedge clk) begin
    if (rd_valid) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_underrun: rd_valid with data %0d, none expected", rd_data);
      end else begin
        sb_exp = sb.pop_front();
        if (rd_data !== sb_exp) begin
          failures++;
          $display("FAIL rd_data: got %0d expected %0d", rd_data, sb_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic drive(input logic en, input logic ps, input logic pp, input logic [DATA_W-1:0] d);
    enable  = en;
    push    = ps;
    pop     = pp;
    data_in = d;
    #1;
  endtask

  task automatic do_reset(input logic [ADDR_W-1:0] th, input logic [ADDR_W-1:0] tl);
    reset_L = 1'b0;
    enable  = 1'b1;
    push    = 1'b0;
    pop     = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    th_high = th;
    th_low  = tl;
    reset_L = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b1, 1'b0, DATA_W'(base + i));
      sb.push_back(DATA_W'(base + i));
      tick();
    end
  endtask

  task automatic test_reset;
    reset_L = 1'b1;
    #2;
    reset_L = 1'b0;
    enable  = 1'b1;
    push    = 1'b1;
    data_in = 4'd5;
    #1;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL rst_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_empty: got %0b expected 1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL rst_full: got %0b expected 0", full); end
    checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL rst_almost_empty: got %0b expected 1", almost_empty); end
    checks++; if (ram_state !== 2'd0) begin failures++; $display("FAIL rst_ram_state: got %0d expected 0", ram_state); end
    checks++; if (error !== 1'b0 || rd_valid !== 1'b0) begin failures++; $display("FAIL rst_err_rdv: got %0b/%0b expected 0/0", error, rd_valid); end
    push = 1'b0;
    do_reset(3'd7, 3'd1);
    checks++; if (dut.state !== ST_IDLE) begin failures++; $display("FAIL init_to_idle: got state %0d expected %0d", dut.state, ST_IDLE); end
  endtask

  task automatic test_fill_drain;
    do_reset(3'd7, 3'd1);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, DATA_W'(i + 1));
      sb.push_back(DATA_W'(i + 1));
      checks++; if (ram_state !== RAM_WR) begin failures++; $display("FAIL fill_ram_state i=%0d: got %0d expected 2", i, ram_state); end
      checks++; if (ram_addr_in !== ADDR_W'(i)) begin failures++; $display("FAIL fill_addr_in i=%0d: got %0d expected %0d", i, ram_addr_in, i); end
      tick();
    end
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL fill_count: got %0d expected 8", count); end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full: got %0b expected 1", full); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b1, '0);
      checks++; if (ram_state !== RAM_RD) begin failures++; $display("FAIL drain_ram_state i=%0d: got %0d expected 1", i, ram_state); end
      checks++; if (ram_addr_out !== ADDR_W'(i)) begin failures++; $display("FAIL drain_addr_out i=%0d: got %0d expected %0d", i, ram_addr_out, i); end
      tick();
      checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL drain_rd_valid i=%0d: got %0b expected 1", i, rd_valid); end
    end
    checks++; if (empty !== 1'b1 || count !== 4'd0) begin failures++; $display("FAIL drain_empty: got empty=%0b count=%0d expected 1/0", empty, count); end
    checks++; if (dut.state !== ST_IDLE) begin failures++; $display("FAIL drain_state: got %0d expected %0d", dut.state, ST_IDLE); end
    tick();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL drain_rd_valid_drop: got %0b expected 0", rd_valid); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL drain_sb_left: got %0d entries expected 0", sb.size()); end
  endtask

  task automatic test_simultaneous;
    do_reset(3'd7, 3'd1);
    fill(8, 9);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, DATA_W'(i));
      sb.push_back(DATA_W'(i));
      checks++; if (ram_state !== RAM_RW) begin failures++; $display("FAIL rw_ram_state i=%0d: got %0d expected 3", i, ram_state); end
      checks++; if (ram_addr_in !== ADDR_W'(i) || ram_addr_out !== ADDR_W'(i)) begin failures++; $display("FAIL rw_addr i=%0d: got wr=%0d rd=%0d expected %0d", i, ram_addr_in, ram_addr_out, i); end
      tick();
      checks++; if (count !== 4'd8) begin failures++; $display("FAIL rw_count i=%0d: got %0d expected 8", i, count); end
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b1, '0);
      tick();
    end
    tick();
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL rw_sb_left: got %0d entries expected 0", sb.size()); end
  endtask

  task automatic test_thresholds;
    do_reset(3'd6, 3'd2);
    checks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin failures++; $display("FAIL th_start: got ae=%0b af=%0b expected 1/0", almost_empty, almost_full); end
    for (int n = 1; n <= 6; n++) begin
      drive(1'b1, 1'b1, 1'b0, DATA_W'(n));
      sb.push_back(DATA_W'(n));
      tick();
      checks++; if (almost_full !== (n >= 6)) begin failures++; $display("FAIL th_almost_full n=%0d: got %0b expected %0b", n, almost_full, (n >= 6)); end
      checks++; if (almost_empty !== (n <= 2)) begin failures++; $display("FAIL th_almost_empty n=%0d: got %0b expected %0b", n, almost_empty, (n <= 2)); end
    end
  endtask

  task automatic test_overflow;
    do_reset(3'd7, 3'd1);
    fill(8, 1);
    drive(1'b1, 1'b1, 1'b0, 4'hF);
    checks++; if (ram_state !== RAM_IDLE) begin failures++; $display("FAIL ovf_ram_state: got %0d expected 0", ram_state); end
    tick();
    checks++; if (error !== 1'b1 || count !== 4'd8) begin failures++; $display("FAIL ovf_error: got error=%0b count=%0d expected 1/8", error, count); end
    checks++; if (dut.state !== ST_ERROR) begin failures++; $display("FAIL ovf_state: got %0d expected %0d", dut.state, ST_ERROR); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 4'h3);
      checks++; if (ram_state !== RAM_IDLE) begin failures++; $display("FAIL err_ram_state i=%0d: got %0d expected 0", i, ram_state); end
      tick();
      checks++; if (error !== 1'b1 || count !== 4'd8) begin failures++; $display("FAIL err_sticky i=%0d: got error=%0b count=%0d expected 1/8", i, error, count); end
    end
    reset_L = 1'b0;
    sb.delete();
    #1;
    checks++; if (error !== 1'b0 || count !== 4'd0) begin failures++; $display("FAIL ovf_reset: got error=%0b count=%0d expected 0/0", error, count); end
  endtask

  task automatic test_underflow;
    do_reset(3'd7, 3'd1);
    fill(1, 3);
    drive(1'b1, 1'b0, 1'b1, '0);
    tick();
    tick();
    drive(1'b1, 1'b1, 1'b1, 4'd5);
    checks++; if (ram_state !== RAM_WR) begin failures++; $display("FAIL udf_ram_state: got %0d expected 2", ram_state); end
    tick();
    checks++; if (count !== 4'd1 || error !== 1'b1) begin failures++; $display("FAIL udf_result: got count=%0d error=%0b expected 1/1", count, error); end
    checks++; if (dut.state !== ST_ERROR) begin failures++; $display("FAIL udf_state: got %0d expected %0d", dut.state, ST_ERROR); end
  endtask

  task automatic test_enable;
    do_reset(3'd7, 3'd1);
    fill(2, 4);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 4'd9);
      checks++; if (ram_state !== RAM_IDLE) begin failures++; $display("FAIL en_ram_state i=%0d: got %0d expected 0", i, ram_state); end
      tick();
      checks++; if (count !== 4'd2 || error !== 1'b0) begin failures++; $display("FAIL en_hold i=%0d: got count=%0d error=%0b expected 2/0", i, count, error); end
    end
    drive(1'b1, 1'b1, 1'b0, 4'd7);
    reset_L = 1'b0;
    sb.delete();
    #1;
    checks++; if (count !== 4'd0 || empty !== 1'b1) begin failures++; $display("FAIL async_reset: got count=%0d empty=%0b expected 0/1", count, empty); end
    checks++; if (ram_state !== RAM_IDLE) begin failures++; $display("FAIL async_reset_ram: got %0d expected 0", ram_state); end
    push = 1'b0;
    do_reset(3'd7, 3'd1);
  endtask

  initial begin
    reset_L = 1'b1;
    enable  = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    data_in = '0;
    th_high = '0;
    th_low  = '0;
    test_reset();
    test_fill_drain();
    test_simultaneous();
    test_thresholds();
    test_overflow();
    test_underflow();
    test_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
